// File: rtl/sized_data_memory.sv
`default_nettype none
// ============================================================================
// sized_data_memory: byte/half/word data memory with Req/Ready handshake and
// registered, extended read data. Macro MISALIGN_SPLIT_EN adds a two-word split
// path for misaligned accesses; otherwise they complete as faults.
// Revision: 1.0
// ============================================================================
module sized_data_memory #(
    parameter int DEPTH = 256
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        Req,
    output logic        Ready,
    input  logic        MemWrite,
    input  logic [1:0]  Size,
    input  logic        Unsigned,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Done,
    output logic        Fault
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_RSVD = 2'b11;

    logic [31:0]   r_mem [DEPTH];

    logic [AW-1:0] w_idx;
    logic [1:0]    w_off;
    logic [3:0]    w_mask;
    logic [7:0]    w_be;
    logic [63:0]   w_wd;
    logic [31:0]   w_rd_word;
    logic          w_accept;
    logic          w_misal;
    logic          w_fault;
    logic          w_wr_lo;

    function automatic logic [31:0] f_ext(input logic [31:0] raw,
                                          input logic [1:0]  sz,
                                          input logic        uns);
        logic [31:0] v;
        case (sz)
            c_SZ_BYTE: v = uns ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            c_SZ_HALF: v = uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default:   v = raw;
        endcase
        return v;
    endfunction

    assign w_idx     = Address[AW+1:2];
    assign w_off     = Address[1:0];
    assign w_accept  = Req && Ready;
    assign w_misal   = ((Size == c_SZ_HALF) && w_off[0]) ||
                       ((Size == 2'b10) && (w_off != 2'b00));
    assign w_mask    = (Size == c_SZ_BYTE) ? 4'b0001 :
                       (Size == c_SZ_HALF) ? 4'b0011 : 4'b1111;
    // Lanes [7:4] / bits [63:32] address the following word of a split access.
    assign w_be      = {4'b0000, w_mask} << w_off;
    assign w_wd      = {32'd0, WriteData} << {w_off, 3'b000};
    assign w_rd_word = r_mem[w_idx];
    assign w_wr_lo   = w_accept && MemWrite && !w_fault;

`ifdef MISALIGN_SPLIT_EN
    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_SPLIT = 1'b1;

    logic [0:0]    r_state;
    logic [0:0]    w_next;
    logic [AW-1:0] r_idx_hi;
    logic [1:0]    r_off;
    logic [1:0]    r_size;
    logic          r_uns;
    logic          r_write;
    logic [31:0]   r_lo;
    logic [31:0]   r_wd_hi;
    logic [3:0]    r_be_hi;
    logic [63:0]   w_comb;
    logic          w_wr_hi;
    logic          w_unused;

    assign w_fault  = (Size == c_SZ_RSVD);
    assign w_wr_hi  = (r_state == c_SPLIT) && r_write;
    assign w_comb   = {r_mem[r_idx_hi], r_lo} >> {r_off, 3'b000};
    assign w_unused = &{1'b0, Address[31:AW+2], w_comb[63:32]};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (w_accept && w_misal && !w_fault) w_next = c_SPLIT;
            c_SPLIT: w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    always_comb begin
        Ready = Reset_n && (r_state == c_IDLE);
    end

    // Request context held for the second half of a split access.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_idx_hi <= '0;
            r_off    <= 2'b00;
            r_size   <= 2'b00;
            r_uns    <= 1'b0;
            r_write  <= 1'b0;
            r_lo     <= 32'd0;
            r_wd_hi  <= 32'd0;
            r_be_hi  <= 4'd0;
        end else if (w_accept) begin
            r_idx_hi <= w_idx + AW'(1);
            r_off    <= w_off;
            r_size   <= Size;
            r_uns    <= Unsigned;
            r_write  <= MemWrite;
            r_lo     <= w_rd_word;
            r_wd_hi  <= w_wd[63:32];
            r_be_hi  <= w_be[7:4];
        end
    end
`else
    logic w_unused;

    assign w_fault  = (Size == c_SZ_RSVD) || w_misal;
    assign Ready    = Reset_n;
    assign w_unused = &{1'b0, Address[31:AW+2], w_be[7:4], w_wd[63:32]};
`endif

    // Storage is deliberately not reset.
    always_ff @(posedge Clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_wr_lo && w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wd[8*b +: 8];
`ifdef MISALIGN_SPLIT_EN
            if (w_wr_hi && r_be_hi[b]) r_mem[r_idx_hi][8*b +: 8] <= r_wd_hi[8*b +: 8];
`endif
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ReadData <= 32'd0;
            Done     <= 1'b0;
            Fault    <= 1'b0;
        end else begin
            Done  <= 1'b0;
            Fault <= 1'b0;
            if (w_accept) begin
                if (w_fault) begin
                    Done     <= 1'b1;
                    Fault    <= 1'b1;
                    ReadData <= 32'd0;
                end else if (!w_misal) begin
                    Done <= 1'b1;
                    if (!MemWrite) ReadData <= f_ext(w_rd_word >> {w_off, 3'b000}, Size, Unsigned);
                end
            end
`ifdef MISALIGN_SPLIT_EN
            if (r_state == c_SPLIT) begin
                Done <= 1'b1;
                if (!r_write) ReadData <= f_ext(w_comb[31:0], r_size, r_uns);
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sized_data_memory.sv
`default_nettype none
// Testbench for sized_data_memory: randomized and directed traffic scored
// against a byte-array reference model through an expected-response queue.
module tb_sized_data_memory;
    localparam int DEPTH = 32;
    localparam int NB    = 4 * DEPTH;
`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Req = 1'b0;
    logic        Ready;
    logic        MemWrite = 1'b0;
    logic [1:0]  Size = 2'b00;
    logic        Unsigned = 1'b0;
    logic [31:0] Address = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic [31:0] ReadData;
    logic        Done;
    logic        Fault;

    typedef struct {
        logic [31:0] rd;
        logic        flt;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        me;
    logic [7:0]  mb [NB];
    logic [31:0] last_rd = 32'd0;
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;

    sized_data_memory #(.DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Ready(Ready),
        .MemWrite(MemWrite), .Size(Size), .Unsigned(Unsigned),
        .Address(Address), .WriteData(WriteData), .ReadData(ReadData),
        .Done(Done), .Fault(Fault)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Monitor: every completion must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (Reset_n && Done) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL spurious_done rd=%h flt=%b cyc=%0d (no request outstanding)", ReadData, Fault, cyc);
            end else begin
                me = sb.pop_front();
                if (ReadData !== me.rd || Fault !== me.flt || cyc != me.due) begin
                    failures++;
                    $display("FAIL completion got rd=%h flt=%b cyc=%0d expected rd=%h flt=%b cyc=%0d",
                             ReadData, Fault, cyc, me.rd, me.flt, me.due);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference model: memory is a flat byte array indexed modulo its size.
    task automatic model(input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd, input bit abort,
                         output bit flt, output int lat);
        int          n;
        int          a;
        bit          mis;
        logic [31:0] v;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        a   = int'(addr % NB);
        mis = (addr % n) != 0;
        if (sz == 2'd3 || (mis && !SPLIT_EN)) begin
            flt = 1'b1; lat = 1; last_rd = 32'd0;
        end else begin
            flt = 1'b0; lat = mis ? 2 : 1;
            if (wr) begin
                for (int k = 0; k < n; k++)
                    if (!abort || ((a + k) / 4 == a / 4)) mb[(a + k) % NB] = wd[8*k +: 8];
            end else begin
                v = 32'd0;
                for (int k = 0; k < n; k++) v[8*k +: 8] = mb[(a + k) % NB];
                if (n < 4 && !uns && v[8*n-1])
                    for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
                last_rd = v;
            end
        end
    endtask

    task automatic issue(input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [31:0] addr, input logic [31:0] wd, input bit abort);
        bit   flt;
        int   lat;
        int   tries;
        exp_t e;
        @(negedge Clk);
        Req = 1'b1; MemWrite = wr; Size = sz; Unsigned = uns; Address = addr; WriteData = wd;
        tries = 0;
        while (Ready !== 1'b1 && tries < 20) begin
            @(negedge Clk);
            tries++;
        end
        if (Ready !== 1'b1) begin
            checks++; failures++;
            $display("FAIL ready_timeout got=%b expected=1", Ready);
            Req = 1'b0;
            return;
        end
        model(wr, sz, uns, addr, wd, abort, flt, lat);
        e.rd = last_rd; e.flt = flt; e.due = cyc + lat;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        Req = 1'b0; Address = $urandom; WriteData = $urandom; Size = 2'($urandom);
        if (lat == 2) begin
            @(negedge Clk);
            chk("split_ready_low", {31'd0, Ready}, 32'd0);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 10) begin
            @(negedge Clk);
            t++;
        end
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    task automatic reset_checks();
        #1;
        chk("rst_readdata", ReadData, 32'd0);
        chk("rst_done", {31'd0, Done}, 32'd0);
        chk("rst_fault", {31'd0, Fault}, 32'd0);
        chk("rst_ready", {31'd0, Ready}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("post_rst_ready", {31'd0, Ready}, 32'd1);
        last_rd = 32'd0;
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        reset_checks();

        for (int w = 0; w < DEPTH; w++) issue(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 1'b0);

        issue(1'b1, 2'd2, 1'b0, 32'h64, 32'hAABBCCDD, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h64, 32'd0, 1'b0);
        drain();
        chk("word_load", ReadData, 32'hAABBCCDD);
        issue(1'b0, 2'd0, 1'b0, 32'h67, 32'd0, 1'b0);
        drain();
        chk("byte_signed", ReadData, 32'hFFFFFFAA);
        issue(1'b0, 2'd0, 1'b1, 32'h67, 32'd0, 1'b0);
        drain();
        chk("byte_unsigned", ReadData, 32'h000000AA);
        issue(1'b1, 2'd1, 1'b0, 32'h66, 32'h67671234, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h64, 32'd0, 1'b0);
        drain();
        chk("half_store", ReadData, 32'h1234CCDD);
        issue(1'b0, 2'd1, 1'b0, 32'h66, 32'd0, 1'b0);
        drain();
        chk("half_load", ReadData, 32'h00001234);

        issue(1'b1, 2'd2, 1'b0, 32'h65, 32'h11223344, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h64, 32'd0, 1'b0);
        issue(1'b0, 2'd0, 1'b0, 32'h68, 32'd0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h65, 32'd0, 1'b0);
        drain();
        chk("split_word_load", ReadData, SPLIT_EN ? 32'h11223344 : 32'd0);
        issue(1'b1, 2'd2, 1'b0, 32'((DEPTH - 1) * 4 + 1), 32'hCAFEF00D, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'd0, 32'd0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'((DEPTH - 1) * 4), 32'd0, 1'b0);

        issue(1'b1, 2'd3, 1'b0, 32'h70, 32'hDEADBEEF, 1'b0);
        drain();
        chk("rsvd_fault_rd", ReadData, 32'd0);
        issue(1'b0, 2'd2, 1'b0, 32'h70, 32'd0, 1'b0);
        issue(1'b1, 2'd1, 1'b0, 32'h65, 32'h0000BEEF, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h64, 32'd0, 1'b0);
        issue(1'b0, 2'd2, 1'b0, 32'h68, 32'd0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(4) == 0) @(negedge Clk);
            issue(1'($urandom), ($urandom_range(7) == 0) ? 2'd3 : 2'($urandom_range(2)),
                  1'($urandom), $urandom, $urandom, 1'b0);
        end

        drain();
        @(negedge Clk);
        Reset_n = 1'b0;
        reset_checks();
        issue(1'b0, 2'd2, 1'b0, 32'h64, 32'd0, 1'b0);

        if (SPLIT_EN) begin
            drain();
            issue(1'b1, 2'd2, 1'b0, 32'h4A, 32'h55667788, 1'b1);
            Reset_n = 1'b0;
            void'(sb.pop_back());
            reset_checks();
            issue(1'b0, 2'd2, 1'b0, 32'h48, 32'd0, 1'b0);
            issue(1'b0, 2'd2, 1'b0, 32'h4C, 32'd0, 1'b0);
        end

        drain();
        repeat (3) @(negedge Clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL global_timeout cyc=%0d expected completion before limit", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
